// File: rtl/cache_mem_rsp_if.sv
// Refill request / line-burst response channel between the cache and its
// memory responder.
//   req_valid/req_ready/req_addr : one line-fill request (byte address)
//   rsp_valid/rsp_ready/rsp_data/rsp_last : line returned as a beat burst
interface cache_mem_rsp_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_last;

    // Cache (requester) side
    modport master (
        output req_valid, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_last
    );

    // Memory responder side
    modport slave (
        input  req_valid, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_last
    );
endinterface

// File: rtl/cache_mem_rsp.sv
// Memory-side responder for cache line refills: accepts one request at a time,
// waits LATENCY cycles, then bursts LINE_WORDS beats from a word-addressed
// array that is filled through a preload port.
//   clk, rst        : clock, asynchronous active-high reset
//   bus (slave)     : request / burst-response handshake channel
//   ld_we/addr/data : preload write port, honoured only while idle
//   busy            : transaction in progress (not idle)
//   ld_err          : sticky, a preload write arrived while busy and was dropped
module cache_mem_rsp #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned MEM_DEPTH  = 1024,
    parameter int unsigned LATENCY    = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    cache_mem_rsp_if.slave               bus,
    input  logic                         ld_we,
    input  logic [$clog2(MEM_DEPTH)-1:0] ld_addr,
    input  logic [DATA_W-1:0]            ld_data,
    output logic                         busy,
    output logic                         ld_err
);
    localparam int unsigned IDX_W  = $clog2(MEM_DEPTH);
    localparam int unsigned OFF_W  = $clog2(LINE_WORDS);
    localparam int unsigned LINE_W = IDX_W - OFF_W;
    localparam int unsigned CNT_W  = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_BURST = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic [OFF_W-1:0]  beat_q, beat_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ld_err_q, ld_err_d;

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    // Line number within the array: word offset bits and upper address bits drop out
    logic [LINE_W-1:0] req_line;
    assign req_line = bus.req_addr[IDX_W+1:OFF_W+2];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.req_addr[ADDR_W-1:IDX_W+2], bus.req_addr[OFF_W+1:0]};

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        line_d   = line_q;
        beat_d   = beat_q;
        cnt_d    = cnt_q;
        ld_err_d = ld_err_q | (ld_we && (state_q != S_IDLE));
        case (state_q)
            S_IDLE: begin
                // Preload wins over a simultaneous request
                if (bus.req_valid && !ld_we) begin
                    line_d = req_line;
                    beat_d = '0;
                    if (LATENCY > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_W'(LATENCY);
                    end else begin
                        state_d = S_BURST;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_BURST;
                end
            end
            S_BURST: begin
                if (bus.rsp_ready) begin
                    beat_d = beat_q + OFF_W'(1);
                    if (beat_q == OFF_W'(LINE_WORDS - 1)) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and control registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            line_q   <= '0;
            beat_q   <= '0;
            cnt_q    <= '0;
            ld_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            line_q   <= line_d;
            beat_q   <= beat_d;
            cnt_q    <= cnt_d;
            ld_err_q <= ld_err_d;
        end
    end

    // Backing array: not reset, written only while idle so burst data stays stable
    always_ff @(posedge clk) begin
        if (ld_we && (state_q == S_IDLE)) begin
            mem[ld_addr] <= ld_data;
        end
    end

    // Outputs decode registered state; rsp_data is a combinational array read
    assign bus.req_ready = (state_q == S_IDLE) && !ld_we;
    assign bus.rsp_valid = (state_q == S_BURST);
    assign bus.rsp_last  = (state_q == S_BURST) && (beat_q == OFF_W'(LINE_WORDS - 1));
    assign bus.rsp_data  = (state_q == S_BURST) ? mem[{line_q, beat_q}] : '0;
    assign busy          = (state_q != S_IDLE);
    assign ld_err        = ld_err_q;
endmodule

// File: tb/tb_cache_mem_rsp.sv
module tb_cache_mem_rsp;
    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned LW    = 4;
    localparam int unsigned DEPTH = 1024;
    localparam int unsigned LAT   = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    cache_mem_rsp_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    cache_mem_rsp_if #(.ADDR_W(AW), .DATA_W(DW)) zbus ();

    logic          ld_we   = 1'b0;
    logic [9:0]    ld_addr = '0;
    logic [DW-1:0] ld_data = '0;
    logic          busy, ld_err;
    logic          zld_we   = 1'b0;
    logic [9:0]    zld_addr = '0;
    logic [DW-1:0] zld_data = '0;
    logic          zbusy, zld_err;

    cache_mem_rsp #(.ADDR_W(AW), .DATA_W(DW), .LINE_WORDS(LW), .MEM_DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
        .busy(busy), .ld_err(ld_err)
    );

    cache_mem_rsp #(.ADDR_W(AW), .DATA_W(DW), .LINE_WORDS(LW), .MEM_DEPTH(DEPTH), .LATENCY(0)) dut_z (
        .clk(clk), .rst(rst), .bus(zbus),
        .ld_we(zld_we), .ld_addr(zld_addr), .ld_data(zld_data),
        .busy(zbusy), .ld_err(zld_err)
    );

    initial forever #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model of the main DUT
    logic [DW-1:0] shadow [DEPTH];
    bit            m_busy = 1'b0;
    int            m_wait = 0;
    logic [DW-1:0] m_q [$];
    bit            m_err  = 1'b0;
    int            m_base = 0;
    int            cyc    = 0;
    int            acc_cyc [$];
    logic [DW-1:0] hs_data [$];
    int            hs_cyc  [$];
    int            valid_cycles = 0;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_busy = 1'b0;
            m_wait = 0;
            m_err  = 1'b0;
            m_q.delete();
        end else begin
            cyc++;
            if (!m_busy) begin
                if (ld_we) begin
                    shadow[ld_addr] = ld_data;
                end else if (bus.req_valid) begin
                    m_base = int'((bus.req_addr >> 2) % DEPTH);
                    m_base = m_base - (m_base % LW);
                    for (int i = 0; i < LW; i++) m_q.push_back(shadow[m_base + i]);
                    m_wait = LAT;
                    m_busy = 1'b1;
                    acc_cyc.push_back(cyc);
                end
            end else begin
                if (ld_we) m_err = 1'b1;
                if (m_wait > 0) begin
                    m_wait--;
                end else if (bus.rsp_ready) begin
                    void'(m_q.pop_front());
                    if (m_q.size() == 0) m_busy = 1'b0;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    initial forever begin
        bit exp_v;
        @(negedge clk);
        exp_v = m_busy && (m_wait == 0);
        chk("req_ready", bus.req_ready, !m_busy && !ld_we);
        chk("rsp_valid", bus.rsp_valid, exp_v);
        chk("rsp_last", bus.rsp_last, exp_v && (m_q.size() == 1));
        chk("rsp_data", bus.rsp_data, exp_v ? m_q[0] : 32'h0);
        chk("busy", busy, m_busy);
        chk("ld_err", ld_err, m_err);
        if (bus.rsp_valid) valid_cycles++;
        if (bus.rsp_valid && bus.rsp_ready) begin
            hs_data.push_back(bus.rsp_data);
            hs_cyc.push_back(cyc);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int a, input logic [DW-1:0] d);
        ld_we   = 1'b1;
        ld_addr = 10'(a);
        ld_data = d;
        step();
        ld_we   = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 60 && busy; i++) step();
        chk(name, busy, 1'b0);
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 20 && !bus.rsp_valid; i++) step();
        chk(name, bus.rsp_valid, 1'b1);
    endtask

    task automatic request(input logic [AW-1:0] a);
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        step();
        bus.req_valid = 1'b0;
    endtask

    task automatic expect_line(input string nm, input int n,
                               input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                               input logic [DW-1:0] e2, input logic [DW-1:0] e3);
        logic [DW-1:0] e [4];
        e = '{e0, e1, e2, e3};
        chk({nm, "_count"}, 32'(hs_data.size() >= n + 4), 32'd1);
        for (int i = 0; i < 4; i++) chk(nm, hs_data[n + i], e[i]);
    endtask

    bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    int n0, a0, vc0;

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_addr   = '0;
        bus.rsp_ready  = 1'b0;
        zbus.req_valid = 1'b0;
        zbus.req_addr  = '0;
        zbus.rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", bus.req_ready, 1'b1);
        chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_rsp_last", bus.rsp_last, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ld_err", ld_err, 1'b0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 8; i++) preload(i, 32'h100 + 32'(i));
        for (int i = 0; i < 4; i++) preload(1020 + i, 32'hA00 + 32'(i));

        // Basic fill: beats in cycles 4..7, req_ready back in cycle 8
        n0 = hs_data.size();
        bus.rsp_ready = 1'b1;
        request(32'h14);
        repeat (6) step();
        chk("basic_last", bus.rsp_last, 1'b1);
        chk("basic_last_data", bus.rsp_data, 32'h107);
        step();
        chk("basic_ready_c8", bus.req_ready, 1'b1);
        expect_line("basic_data", n0, 32'h104, 32'h105, 32'h106, 32'h107);
        for (int i = 0; i < 4; i++)
            chk("basic_beat_cycle", 32'(hs_cyc[n0 + i] - acc_cyc[acc_cyc.size() - 1] + 1), 32'(4 + i));

        // Backpressure 1,0,0,1,0,1,1 over the burst
        n0 = hs_data.size();
        vc0 = valid_cycles;
        bus.rsp_ready = 1'b0;
        request(32'h14);
        wait_valid("bp_first_valid");
        for (int i = 0; i < 7; i++) begin
            bus.rsp_ready = pat[i];
            step();
        end
        bus.rsp_ready = 1'b1;
        chk("bp_idle", busy, 1'b0);
        chk("bp_handshakes", 32'(hs_data.size() - n0), 32'd4);
        chk("bp_burst_len", 32'(valid_cycles - vc0), 32'd7);
        expect_line("bp_data", n0, 32'h104, 32'h105, 32'h106, 32'h107);

        // Address wrap on the main responder
        n0 = hs_data.size();
        request(32'h1000_0FF0);
        wait_idle("wrap_done");
        expect_line("wrap_data", n0, 32'hA00, 32'hA01, 32'hA02, 32'hA03);

        // Zero-latency responder: first beat the cycle after acceptance, wrapped words
        for (int i = 0; i < 4; i++) begin
            zld_we   = 1'b1;
            zld_addr = 10'(1020 + i);
            zld_data = 32'hB00 + 32'(i);
            step();
        end
        zld_we = 1'b0;
        zbus.rsp_ready = 1'b1;
        zbus.req_valid = 1'b1;
        zbus.req_addr  = 32'h1000_0FF0;
        step();
        zbus.req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("z_valid", zbus.rsp_valid, 1'b1);
            chk("z_data", zbus.rsp_data, 32'hB00 + 32'(i));
            chk("z_last", zbus.rsp_last, i == 3);
            step();
        end
        chk("z_idle", zbusy, 1'b0);
        chk("z_ready", zbus.req_ready, 1'b1);
        chk("z_ld_err", zld_err, 1'b0);

        // Preload and request together: preload wins, request follows
        n0 = hs_data.size();
        a0 = acc_cyc.size();
        ld_we = 1'b1;
        ld_addr = 10'd2;
        ld_data = 32'h222;
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h0;
        #1;
        chk("ldreq_ready_low", bus.req_ready, 1'b0);
        step();
        ld_we = 1'b0;
        chk("ldreq_not_accepted", busy, 1'b0);
        step();
        bus.req_valid = 1'b0;
        chk("ldreq_accepted", busy, 1'b1);
        chk("ldreq_acc_count", 32'(acc_cyc.size() - a0), 32'd1);
        wait_idle("ldreq_done");
        expect_line("ldreq_data", n0, 32'h100, 32'h101, 32'h222, 32'h103);

        // Preload during burst is dropped and flagged
        n0 = hs_data.size();
        request(32'h14);
        wait_valid("ldb_valid");
        ld_we = 1'b1;
        ld_addr = 10'd5;
        ld_data = 32'hDEAD;
        step();
        ld_we = 1'b0;
        chk("ldb_err_set", ld_err, 1'b1);
        wait_idle("ldb_done");
        expect_line("ldb_data", n0, 32'h104, 32'h105, 32'h106, 32'h107);
        n0 = hs_data.size();
        request(32'h14);
        wait_idle("ldb_refill_done");
        chk("ldb_err_sticky", ld_err, 1'b1);
        expect_line("ldb_array", n0, 32'h104, 32'h105, 32'h106, 32'h107);

        // Reset after beat 2 aborts at once; memory survives
        n0 = hs_data.size();
        request(32'h14);
        for (int i = 0; i < 20 && (hs_data.size() - n0 < 2); i++) step();
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", bus.rsp_valid, 1'b0);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_last", bus.rsp_last, 1'b0);
        chk("rst_mid_ld_err", ld_err, 1'b0);
        step();
        rst = 1'b0;
        chk("rst_mid_beats", 32'(hs_data.size() - n0), 32'd2);
        step();
        n0 = hs_data.size();
        request(32'h14);
        wait_idle("rst_refill_done");
        expect_line("rst_refill", n0, 32'h104, 32'h105, 32'h106, 32'h107);

        // Back-to-back requests held valid
        n0 = hs_data.size();
        a0 = acc_cyc.size();
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h14;
        step();
        bus.req_addr  = 32'h0;
        for (int i = 0; i < 40 && (acc_cyc.size() < a0 + 2); i++) step();
        bus.req_valid = 1'b0;
        chk("b2b_acc_count", 32'(acc_cyc.size() - a0), 32'd2);
        wait_idle("b2b_done");
        chk("b2b_spacing", 32'(acc_cyc[a0 + 1] - acc_cyc[a0]), 32'd8);
        chk("b2b_after_last", 32'(acc_cyc[a0 + 1] - hs_cyc[n0 + 3]), 32'd2);
        expect_line("b2b_first", n0, 32'h104, 32'h105, 32'h106, 32'h107);
        expect_line("b2b_second", n0 + 4, 32'h100, 32'h101, 32'h222, 32'h103);

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
